fnd_scan_controller: RTL and testbench

//  Drives the 4-digit common-anode FND from the 14-bit binary count and per-digit dot mask of the up/down counter.

---
 rtl/fnd_scan_controller_pkg.sv | 56 +++++
 rtl/fnd_scan_controller_if.sv | 16 +
 rtl/fnd_scan_controller_bin2bcd_seq.sv | 77 +++++++
 rtl/fnd_scan_controller.sv | 165 ++++++++++++++++
 tb/tb_fnd_scan_controller.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/fnd_scan_controller_pkg.sv
// Shared constants for the FND scan controller.
//  - Segment font codes (7 LSBs of fndFont, active-low {g,f,e,d,c,b,a})
//  - Digit count and converter state encoding
//  - Helpers: segment decode and the double-dabble add-3 correction step
package fnd_scan_controller_pkg;

   localparam int DIGIT_COUNT = 4;

   localparam logic [6:0] FONT_0     = 7'h40;
   localparam logic [6:0] FONT_1     = 7'h79;
   localparam logic [6:0] FONT_2     = 7'h24;
   localparam logic [6:0] FONT_3     = 7'h30;
   localparam logic [6:0] FONT_4     = 7'h19;
   localparam logic [6:0] FONT_5     = 7'h12;
   localparam logic [6:0] FONT_6     = 7'h02;
   localparam logic [6:0] FONT_7     = 7'h78;
   localparam logic [6:0] FONT_8     = 7'h00;
   localparam logic [6:0] FONT_9     = 7'h10;
   localparam logic [6:0] FONT_BLANK = 7'h7F;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } conv_state_e;

   // BCD digit to active-low segments; anything above 9 is shown dark.
   function automatic logic [6:0] font7(input logic [3:0] digit);
      logic [6:0] seg;
      case (digit)
         4'd0:    seg = FONT_0;
         4'd1:    seg = FONT_1;
         4'd2:    seg = FONT_2;
         4'd3:    seg = FONT_3;
         4'd4:    seg = FONT_4;
         4'd5:    seg = FONT_5;
         4'd6:    seg = FONT_6;
         4'd7:    seg = FONT_7;
         4'd8:    seg = FONT_8;
         4'd9:    seg = FONT_9;
         default: seg = FONT_BLANK;
      endcase
      return seg;
   endfunction

   // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
   function automatic logic [15:0] bcd_add3(input logic [15:0] bcd);
      logic [15:0] res;
      res = bcd;
      for (int i = 0; i < 4; i++) begin
         res[i*4 +: 4] = (res[i*4 +: 4] >= 4'd5) ? (res[i*4 +: 4] + 4'd3) : res[i*4 +: 4];
      end
      return res;
   endfunction

endpackage

// File: rtl/fnd_scan_controller_if.sv
// FND display bus: value/dot inputs from the counter, digit/segment outputs.
//  fndData [13:0] binary value, fndDot [3:0] active-low dp per digit,
//  fndCom  [3:0]  active-low one-hot digit select, fndFont [7:0] {dp,g..a} active-low.
//  master: the side producing data (counter / bench); slave: the scan controller.
interface fnd_scan_controller_if;
   import fnd_scan_controller_pkg::*;

   logic [13:0] fndData;
   logic [3:0]  fndDot;
   logic [3:0]  fndCom;
   logic [7:0]  fndFont;

   modport master (output fndData, output fndDot, input fndCom, input fndFont);
   modport slave  (input fndData, input fndDot, output fndCom, output fndFont);

endinterface

// File: rtl/fnd_scan_controller_bin2bcd_seq.sv
// Sequential 14-bit binary to 4-digit BCD converter (double dabble).
//  clk, reset (async active-low), start (accepted only in IDLE), bin[13:0]
//  busy (not IDLE), done (1-cycle pulse while result valid), bcd[15:0]
// One load cycle, 14 add-3/shift cycles, one DONE cycle.
module bin2bcd_seq
   import fnd_scan_controller_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [13:0] bin,
   output logic        busy,
   output logic        done,
   output logic [15:0] bcd
);

   conv_state_e r_state;
   conv_state_e w_state_next;
   logic [13:0] r_sr;
   logic [15:0] r_bcd;
   logic [3:0]  r_cnt;
   logic [15:0] w_adj;

   assign w_adj = bcd_add3(r_bcd);

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic; the 14th shift happens on the edge leaving SHIFT.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:  w_state_next = start ? ST_SHIFT : ST_IDLE;
         ST_SHIFT: w_state_next = (r_cnt == 4'd13) ? ST_DONE : ST_SHIFT;
         ST_DONE:  w_state_next = ST_IDLE;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   // Datapath: load on start, then add-3 and shift one binary bit per cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sr  <= 14'd0;
         r_bcd <= 16'd0;
         r_cnt <= 4'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_sr  <= bin;
                  r_bcd <= 16'd0;
                  r_cnt <= 4'd0;
               end
            end
            ST_SHIFT: begin
               r_bcd <= {w_adj[14:0], r_sr[13]};
               r_sr  <= {r_sr[12:0], 1'b0};
               r_cnt <= r_cnt + 4'd1;
            end
            default: begin
               r_cnt <= r_cnt;
            end
         endcase
      end
   end

   assign busy = (r_state != ST_IDLE);
   assign done = (r_state == ST_DONE);
   assign bcd  = r_bcd;

endmodule

// File: rtl/fnd_scan_controller.sv
// 4-digit common-anode FND scan controller.
//  clk, reset (async active-low); fnd (slave modport): fndData/fndDot in, fndCom/fndFont out.
// A frame is idx 0..3. Inputs are captured on the tick 2->3 and converted to BCD;
// the result becomes visible on the tick 3->0, so a frame never mixes two samples.
// Optional feature macro: LEADING_ZERO_BLANK_EN (dark leading zeros, ones digit always lit).
module fnd_scan_controller
   import fnd_scan_controller_pkg::*;
#(
   parameter int CLK_HZ   = 100_000_000,
   parameter int SCAN_HZ  = 1000,
   parameter int DATA_MAX = 9999
) (
   input logic                clk,
   input logic                reset,
   fnd_scan_controller_if.slave fnd
);

   localparam int DIV   = CLK_HZ / SCAN_HZ;
   localparam int DIV_W = $clog2(DIV);

   // The converter needs 16 cycles between capture and commit.
   if (DIV < 17) begin : g_div_check
      $error("fnd_scan_controller: CLK_HZ/SCAN_HZ must be at least 17");
   end

   logic [DIV_W-1:0] r_div;
   logic [1:0]       r_idx;
   logic [13:0]      r_shadow_bin;
   logic [3:0]       r_shadow_dot;
   logic             r_start;
   logic [15:0]      r_pend_bcd;
   logic [3:0]       r_pend_dot;
   logic [15:0]      r_disp_bcd;
   logic [3:0]       r_disp_dot;
   logic [3:0]       r_com;
   logic [7:0]       r_font;

   logic             w_tick;
   logic [1:0]       w_idx_next;
   logic             w_capture;
   logic             w_commit;
   logic [13:0]      w_sat;
   logic             w_busy;
   logic             w_done;
   logic [15:0]      w_bcd;
   logic [15:0]      w_src_bcd;
   logic [3:0]       w_src_dot;
   logic [3:0]       w_src_blank;
   logic [3:0]       w_digit;
   logic [6:0]       w_seg;

   assign w_tick     = (r_div == DIV_W'(DIV - 1));
   assign w_idx_next = r_idx + 2'd1;
   assign w_capture  = w_tick && (r_idx == 2'd2);
   assign w_commit   = w_tick && (r_idx == 2'd3);
   assign w_sat      = ({18'd0, fnd.fndData} > 32'(DATA_MAX)) ? 14'(DATA_MAX) : fnd.fndData;

   bin2bcd_seq u_bin2bcd (
      .clk   (clk),
      .reset (reset),
      .start (r_start & ~w_busy),
      .bin   (r_shadow_bin),
      .busy  (w_busy),
      .done  (w_done),
      .bcd   (w_bcd)
   );

`ifdef LEADING_ZERO_BLANK_EN
   logic [3:0] r_blank;
   logic [3:0] w_lz_mask;

   // Leading-zero mask of the frame about to be committed; digit 0 never blanks.
   always_comb begin
      w_lz_mask    = 4'b0000;
      w_lz_mask[3] = (r_pend_bcd[15:12] == 4'd0);
      w_lz_mask[2] = w_lz_mask[3] && (r_pend_bcd[11:8] == 4'd0);
      w_lz_mask[1] = w_lz_mask[2] && (r_pend_bcd[7:4] == 4'd0);
   end

   // Blank mask follows the displayed frame; reset shows a lone "0".
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_blank <= 4'b1110;
      end else if (w_commit) begin
         r_blank <= w_lz_mask;
      end else begin
         r_blank <= r_blank;
      end
   end

   assign w_src_blank = w_commit ? w_lz_mask : r_blank;
`else
   assign w_src_blank = 4'b0000;
`endif

   // Digit shown after this tick: on commit the new frame is already the source.
   always_comb begin
      w_src_bcd = w_commit ? r_pend_bcd : r_disp_bcd;
      w_src_dot = w_commit ? r_pend_dot : r_disp_dot;
      w_digit   = 4'd0;
      case (w_idx_next)
         2'd0:    w_digit = w_src_bcd[3:0];
         2'd1:    w_digit = w_src_bcd[7:4];
         2'd2:    w_digit = w_src_bcd[11:8];
         2'd3:    w_digit = w_src_bcd[15:12];
         default: w_digit = 4'd0;
      endcase
      w_seg = w_src_blank[w_idx_next] ? FONT_BLANK : font7(w_digit);
   end

   // Scan divider, digit index and registered display outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_div  <= '0;
         r_idx  <= 2'd0;
         r_com  <= 4'b1110;
         r_font <= 8'hC0;
      end else if (w_tick) begin
         r_div  <= '0;
         r_idx  <= w_idx_next;
         r_com  <= ~(4'b0001 << w_idx_next);
         r_font <= {w_src_dot[w_idx_next], w_seg};
      end else begin
         r_div  <= r_div + DIV_W'(1);
      end
   end

   // Input capture into shadow regs; the converter starts the following cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_shadow_bin <= 14'd0;
         r_shadow_dot <= 4'b1111;
         r_start      <= 1'b0;
      end else if (w_capture) begin
         r_shadow_bin <= w_sat;
         r_shadow_dot <= fnd.fndDot;
         r_start      <= 1'b1;
      end else begin
         r_start      <= 1'b0;
      end
   end

   // Pending frame (converter result) and displayed frame.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pend_bcd <= 16'd0;
         r_pend_dot <= 4'b1111;
         r_disp_bcd <= 16'd0;
         r_disp_dot <= 4'b1111;
      end else begin
         if (w_done) begin
            r_pend_bcd <= w_bcd;
            r_pend_dot <= r_shadow_dot;
         end
         if (w_commit) begin
            r_disp_bcd <= r_pend_bcd;
            r_disp_dot <= r_pend_dot;
         end
      end
   end

   assign fnd.fndCom  = r_com;
   assign fnd.fndFont = r_font;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Self-checking bench for fnd_scan_controller (CLK_HZ=1000, SCAN_HZ=50 -> 20 cycles/digit).
// A frame-level reference model (decimal arithmetic on the sampled value) predicts
// fndCom/fndFont every cycle; directed steps add fixed expected codes.
module tb_fnd_scan_controller;

   localparam int CLK_HZ  = 1000;
   localparam int SCAN_HZ = 50;
   localparam int DIV     = CLK_HZ / SCAN_HZ;

   logic clk;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;

   fnd_scan_controller_if u_if ();

   fnd_scan_controller #(.CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .DATA_MAX(9999)) dut (
      .clk   (clk),
      .reset (rst_n),
      .fnd   (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Font table straight from the display code list (8-bit with dp off).
   function automatic logic [6:0] seg_of(input int d);
      logic [7:0] s8;
      case (d)
         0: s8 = 8'hC0; 1: s8 = 8'hF9; 2: s8 = 8'hA4; 3: s8 = 8'hB0; 4: s8 = 8'h99;
         5: s8 = 8'h92; 6: s8 = 8'h82; 7: s8 = 8'hF8; 8: s8 = 8'h80; 9: s8 = 8'h90;
         default: s8 = 8'hFF;
      endcase
      return s8[6:0];
   endfunction

   function automatic logic [7:0] model_font(input int val, input logic [3:0] dots, input int d);
      int p;
      logic [6:0] seg;
      p = 1;
      for (int i = 0; i < d; i++) p = p * 10;
      seg = seg_of((val / p) % 10);
`ifdef LEADING_ZERO_BLANK_EN
      if (d > 0 && val < p) seg = 7'h7F;
`endif
      return {dots[d], seg};
   endfunction

   // Reference model: frame sampled at the third tick, shown from the fourth.
   int         m_div, m_idx, m_pend_val, m_disp_val;
   logic [3:0] m_pend_dot, m_disp_dot;
   logic [3:0] exp_com;
   logic [7:0] exp_font;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_div <= 0; m_idx <= 0;
         m_pend_val <= 0; m_pend_dot <= 4'hF;
         m_disp_val <= 0; m_disp_dot <= 4'hF;
         exp_com <= 4'b1110; exp_font <= 8'hC0;
      end else if (m_div == DIV - 1) begin
         m_div <= 0;
         m_idx <= (m_idx + 1) % 4;
         if (m_idx == 2) begin
            m_pend_val <= (int'(u_if.fndData) > 9999) ? 9999 : int'(u_if.fndData);
            m_pend_dot <= u_if.fndDot;
         end
         if (m_idx == 3) begin
            m_disp_val <= m_pend_val;
            m_disp_dot <= m_pend_dot;
         end
         exp_com  <= ~(4'b0001 << ((m_idx + 1) % 4));
         exp_font <= (m_idx == 3) ? model_font(m_pend_val, m_pend_dot, 0)
                                  : model_font(m_disp_val, m_disp_dot, (m_idx + 1) % 4);
      end else begin
         m_div <= m_div + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      chk("model_com", {28'd0, u_if.fndCom}, {28'd0, exp_com});
      chk("model_font", {24'd0, u_if.fndFont}, {24'd0, exp_font});
   endtask

   task automatic run_cycles(input int n);
      repeat (n) begin
         @(negedge clk);
         check_model();
      end
   endtask

   // Wait (bounded) for fndCom to switch to target; returns at that negedge.
   task automatic wait_com(input logic [3:0] target);
      logic [3:0] prev;
      int         n;
      logic       found;
      prev  = u_if.fndCom;
      found = 1'b0;
      n     = 0;
      while (!found && n < 120) begin
         @(negedge clk);
         check_model();
         n++;
         if (u_if.fndCom == target && prev != target) found = 1'b1;
         prev = u_if.fndCom;
      end
      chk("wait_com_timeout", {31'd0, found}, 32'd1);
   endtask

   task automatic check_frame(input string tag, input logic [7:0] f0, input logic [7:0] f1,
                              input logic [7:0] f2, input logic [7:0] f3);
      wait_com(4'b1110); chk({tag, "_d0"}, {24'd0, u_if.fndFont}, {24'd0, f0});
      wait_com(4'b1101); chk({tag, "_d1"}, {24'd0, u_if.fndFont}, {24'd0, f1});
      wait_com(4'b1011); chk({tag, "_d2"}, {24'd0, u_if.fndFont}, {24'd0, f2});
      wait_com(4'b0111); chk({tag, "_d3"}, {24'd0, u_if.fndFont}, {24'd0, f3});
   endtask

`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [7:0] Z_HI  = 8'hFF;
   localparam logic [7:0] Z_HID = 8'h7F;
`else
   localparam logic [7:0] Z_HI  = 8'hC0;
   localparam logic [7:0] Z_HID = 8'h40;
`endif

   initial begin
      rst_n = 1'b0;
      u_if.fndData = 14'd0;
      u_if.fndDot  = 4'b1111;
      repeat (3) @(negedge clk);
      chk("reset_com", {28'd0, u_if.fndCom}, 32'h0000_000E);
      chk("reset_font", {24'd0, u_if.fndFont}, 32'h0000_00C0);
      rst_n = 1'b1;

      // 1: reset mid-frame takes effect immediately, then first tick shows digit 1.
      run_cycles(30);
      rst_n = 1'b0;
      #1;
      chk("t1_rst_com", {28'd0, u_if.fndCom}, 32'h0000_000E);
      chk("t1_rst_font", {24'd0, u_if.fndFont}, 32'h0000_00C0);
      run_cycles(4);
      rst_n = 1'b1;
      wait_com(4'b1101);
      chk("t1_first_tick_font", {24'd0, u_if.fndFont}, {24'd0, Z_HI});

      // 2: 1234
      u_if.fndData = 14'd1234; u_if.fndDot = 4'b1111;
      run_cycles(2 * 4 * DIV);
      check_frame("t2", 8'h99, 8'hB0, 8'hA4, 8'hF9);

      // 3: 5 with dp on digit 1
      u_if.fndData = 14'd5; u_if.fndDot = 4'b1101;
      run_cycles(2 * 4 * DIV);
      check_frame("t3", 8'h92, Z_HID, Z_HI, Z_HI);

      // 4: saturation
      u_if.fndData = 14'd16383; u_if.fndDot = 4'b1111;
      run_cycles(2 * 4 * DIV);
      check_frame("t4", 8'h90, 8'h90, 8'h90, 8'h90);

      // 5: input change right after capture lands one frame later
      u_if.fndData = 14'd1111;
      run_cycles(4 * DIV);
      wait_com(4'b0111);
      @(negedge clk);
      check_model();
      u_if.fndData = 14'd2222;
      check_frame("t5a", 8'hF9, 8'hF9, 8'hF9, 8'hF9);
      check_frame("t5b", 8'hA4, 8'hA4, 8'hA4, 8'hA4);

      // 6: reset during conversion
      u_if.fndData = 14'd9876;
      wait_com(4'b0111);
      run_cycles(3);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_com", {28'd0, u_if.fndCom}, 32'h0000_000E);
      chk("t6_rst_font", {24'd0, u_if.fndFont}, 32'h0000_00C0);
      u_if.fndData = 14'd42;
      run_cycles(2);
      rst_n = 1'b1;
      wait_com(4'b1110);
      chk("t6_d0", {24'd0, u_if.fndFont}, 32'h0000_00A4);
      wait_com(4'b1101);
      chk("t6_d1", {24'd0, u_if.fndFont}, 32'h0000_0099);
      run_cycles(4 * DIV);

      // Randomized values and dots, changed at arbitrary points in the frame.
      for (int it = 0; it < 10; it++) begin
         case ($urandom_range(0, 3))
            0:       u_if.fndData = 14'($urandom_range(0, 99));
            1:       u_if.fndData = 14'($urandom_range(9990, 16383));
            default: u_if.fndData = 14'($urandom_range(0, 16383));
         endcase
         u_if.fndDot = 4'($urandom_range(0, 15));
         run_cycles($urandom_range(5, 4 * DIV * 2));
      end
      run_cycles(2 * 4 * DIV);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
